multilane_scrambler: RTL and testbench
======================================

Name: multilane_scrambler

Overview:
Parametrised successor to the single-lane 66b parallel scrambler. It scrambles or self-synchronously descrambles NB_LANES independent 66b blocks per cycle with the 1+x^39+x^58 polynomial, and the mode is selectable at run time. Each lane adds a valid qualifier, a seed load and a saturating sync-header error counter. The block sits between the 64b/66b encoder/decoder and lane distribution (TX) or deskew (RX).

Parameters:
NB_LANES, 4, number of independent lanes
LEN_CODED_BLOCK, 66, coded block width (2b sync header + 64b payload)
LEN_SCRAMBLER, 58, scrambler state width per lane
SEED, 58'h0, reset value of every lane state
NB_ERR_CNT, 8, width of the per-lane sync-header error counter

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  global clock enable; when low, all state and outputs hold
i_bypass  in  1  pass data unchanged and hold lane states
i_mode  in  1  0 = scramble, 1 = descramble
i_valid  in  NB_LANES  per-lane block valid
i_data  in  NB_LANES*LEN_CODED_BLOCK  lane k occupies bits [k*66 +: 66]
i_seed_load  in  1  load i_seed into all lane states
i_seed  in  LEN_SCRAMBLER  seed value
i_clear_cnt  in  1  clear all error counters
o_data  out  NB_LANES*LEN_CODED_BLOCK  processed blocks, same packing as i_data
o_valid  out  NB_LANES  per-lane output valid
o_sh_error  out  NB_LANES  one-cycle pulse when an invalid header is seen
o_sh_err_cnt  out  NB_LANES*NB_ERR_CNT  per-lane saturating error count

Behaviour:
- Reset is synchronous, active-high, and overrides everything else.
  - Every lane state <= SEED.
  - o_data, o_valid, o_sh_error and o_sh_err_cnt <= 0.
- Latency is 1 cycle, with all outputs registered. Throughput is one block per lane per cycle. There is no backpressure.
- Header bits [65:64] pass through unmodified in every mode. Only payload [63:0] is processed.
- Bit order: payload bit 63 is processed first. State bit 0 is the most recent line bit.
- Scramble: s[n] = d[n] ^ s[n-39] ^ s[n-58].
  - Next state = scrambled payload[57:0].
  - Results must be identical to the existing single-lane scrambler for the same seed and data.
- Descramble: d[n] = r[n] ^ r[n-39] ^ r[n-58], where r is the received payload.
  - Next state = received payload[57:0].
  - The descrambler is self-synchronising: after one valid block, its state is independent of the seed.
- Lane k updates only when i_enable && i_valid[k]. Otherwise the lane state holds, o_valid[k] <= 0 and o_data lane k holds its last value.
- Bypass (i_enable && i_bypass):
  - o_data lane <= i_data lane.
  - o_valid <= i_valid.
  - Lane states hold.
  - Header checking still runs.
- Seed load (i_enable && i_seed_load):
  - All lane states <= i_seed.
  - This takes priority over the data-driven state update in the same cycle.
  - Data in that cycle is still processed with the pre-load state and is output normally.
- Header check, descramble mode only, on valid lanes: a header of 2'b00 or 2'b11 sets o_sh_error[k]=1 for one cycle and increments cnt[k].
  - The counter saturates at all-ones.
  - The payload is still descrambled.
  - The check is not performed in scramble mode.
- i_clear_cnt zeroes all counters.
  - If a clear and an error occur in the same cycle, the counter result is 1.
  - o_sh_error still pulses.
- A change of i_mode takes effect on the next valid block. State is not cleared on a mode change.
- i_enable low: all registers hold, and o_sh_error holds its value (normally 0).

Decomposition:
- Shared package pcs_scrambler_pkg holds:
  - TAP_A=39 and TAP_B=58
  - LEN_PAYLOAD=64 and LEN_SYNC_HEADER=2
  - MODE_SCRAMBLE=0 and MODE_DESCRAMBLE=1
  - SH_DATA=2'b01 and SH_CTRL=2'b10
- One natural sub-module, scrambler_lane_core: combinational, 64b payload + 58b state + mode in; 64b result + next state out.
  - It is instantiated NB_LANES times with a generate loop.
- Registers, valid, seed and counter logic live in the top level.

Test Plan:
1. Scramble mode, SEED=0, all lanes valid, payload 64'h0 with header 2'b01 → o_data = {2'b01, 64'h0} on every lane one cycle later; states stay 0.
2. Loopback: feed random 66b blocks, same seed on both sides, through a scramble instance into a descramble instance → the descrambler output equals the original input for every block and lane after 2 cycles total.
3. Self-sync: scrambler with SEED=58'h0, descrambler with SEED=58'h3FF_FFFF_FFFF_FFFF, random data → block 0 mismatches; every block from 1 onward matches exactly.
4. Bypass: assert i_bypass for 3 blocks mid-stream → o_data equals i_data. After deassertion, the scrambled sequence continues exactly as if those 3 blocks never occurred.
5. Seed load plus valid gating: i_valid=4'b0101, i_seed_load with i_seed=58'h1 in the same cycle → only lanes 0 and 2 output valid with old-state data; the next block on every lane uses state 58'h1.
6. Header errors, descramble mode, NB_ERR_CNT=8:
   - Lane 1 receives 300 blocks with header 2'b00 → o_sh_error[1] pulses on each, cnt[1]=255 (saturated), other lanes' counts stay 0.
   - i_clear_cnt together with one more bad header → cnt[1]=1.

Source files
------------

// File: rtl/pcs_scrambler_pkg.sv
// Shared constants for the 64b/66b PCS scrambler family: polynomial taps,
// block field widths, run-time mode encoding and valid sync headers.
package pcs_scrambler_pkg;

  localparam int unsigned TAP_A           = 39;
  localparam int unsigned TAP_B           = 58;
  localparam int unsigned LEN_PAYLOAD     = 64;
  localparam int unsigned LEN_SYNC_HEADER = 2;

  typedef enum logic {
    MODE_SCRAMBLE   = 1'b0,
    MODE_DESCRAMBLE = 1'b1
  } mode_e;

  localparam logic [LEN_SYNC_HEADER-1:0] SH_DATA = 2'b01;
  localparam logic [LEN_SYNC_HEADER-1:0] SH_CTRL = 2'b10;

endpackage

// File: rtl/scrambler_lane_core.sv
// Combinational 1+x^39+x^58 scrambler/descrambler for one 64b payload.
// Payload bit 63 goes on the line first; state bit 0 holds the newest line bit.
module scrambler_lane_core
  import pcs_scrambler_pkg::*;
#(
  parameter int unsigned LEN_SCRAMBLER = 58
) (
  input  logic [LEN_PAYLOAD-1:0]   payload,
  input  logic [LEN_SCRAMBLER-1:0] state,
  input  mode_e                    mode,
  output logic [LEN_PAYLOAD-1:0]   result,
  output logic [LEN_SCRAMBLER-1:0] next_state
);

  localparam int unsigned IW = $clog2(LEN_PAYLOAD);

  logic [LEN_SCRAMBLER-1:0] shift;
  logic [IW-1:0]            idx;
  logic                     fb;

  // The bit-serial recurrence is unrolled; the shift history feeds back either
  // the scrambled bit (scramble) or the received bit (self-sync descramble).
  always_comb begin
    shift  = state;
    result = '0;
    idx    = '0;
    fb     = 1'b0;
    for (int unsigned i = 0; i < LEN_PAYLOAD; i++) begin
      idx         = IW'(LEN_PAYLOAD - 1 - i);
      fb          = shift[TAP_A-1] ^ shift[TAP_B-1];
      result[idx] = payload[idx] ^ fb;
      shift       = {shift[LEN_SCRAMBLER-2:0],
                     (mode == MODE_DESCRAMBLE) ? payload[idx] : result[idx]};
    end
    next_state = shift;
  end

endmodule

// File: rtl/multilane_scrambler.sv
// NB_LANES independent 66b-block scramblers/descramblers with per-lane valid,
// shared seed load and saturating sync-header error counters.
module multilane_scrambler
  import pcs_scrambler_pkg::*;
#(
  parameter int unsigned              NB_LANES        = 4,
  parameter int unsigned              LEN_CODED_BLOCK = 66,
  parameter int unsigned              LEN_SCRAMBLER   = 58,
  parameter logic [LEN_SCRAMBLER-1:0] SEED            = '0,
  parameter int unsigned              NB_ERR_CNT      = 8
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_enable,
  input  logic                                  i_bypass,
  input  logic                                  i_mode,
  input  logic [NB_LANES-1:0]                   i_valid,
  input  logic [NB_LANES*LEN_CODED_BLOCK-1:0]   i_data,
  input  logic                                  i_seed_load,
  input  logic [LEN_SCRAMBLER-1:0]              i_seed,
  input  logic                                  i_clear_cnt,
  output logic [NB_LANES*LEN_CODED_BLOCK-1:0]   o_data,
  output logic [NB_LANES-1:0]                   o_valid,
  output logic [NB_LANES-1:0]                   o_sh_error,
  output logic [NB_LANES*NB_ERR_CNT-1:0]        o_sh_err_cnt
);

  mode_e mode;
  assign mode = mode_e'(i_mode);

  for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
    localparam int unsigned BASE = k * LEN_CODED_BLOCK;

    logic [LEN_SCRAMBLER-1:0]   state;
    logic [LEN_SCRAMBLER-1:0]   next_state;
    logic [LEN_PAYLOAD-1:0]     result;
    logic [LEN_SYNC_HEADER-1:0] header;
    logic                       bad_header;
    logic [LEN_CODED_BLOCK-1:0] data_q;
    logic                       valid_q;
    logic                       err_q;
    logic [NB_ERR_CNT-1:0]      cnt_q;

    assign header     = i_data[BASE+LEN_PAYLOAD +: LEN_SYNC_HEADER];
    assign bad_header = (mode == MODE_DESCRAMBLE) && i_valid[k] &&
                        (header != SH_DATA) && (header != SH_CTRL);

    scrambler_lane_core #(
      .LEN_SCRAMBLER (LEN_SCRAMBLER)
    ) u_core (
      .payload    (i_data[BASE +: LEN_PAYLOAD]),
      .state      (state),
      .mode       (mode),
      .result     (result),
      .next_state (next_state)
    );

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        state   <= SEED;
        data_q  <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        cnt_q   <= '0;
      end else if (i_enable) begin
        valid_q <= i_valid[k];
        err_q   <= bad_header;

        // A clear coinciding with a bad header leaves that one error counted.
        if (i_clear_cnt)
          cnt_q <= bad_header ? NB_ERR_CNT'(1) : '0;
        else if (bad_header && (cnt_q != '1))
          cnt_q <= cnt_q + 1'b1;

        if (i_valid[k])
          data_q <= i_bypass ? i_data[BASE +: LEN_CODED_BLOCK]
                             : {header, result};

        // Seed load wins over the data-driven update; bypass freezes the lane.
        if (i_seed_load)
          state <= i_seed;
        else if (i_valid[k] && !i_bypass)
          state <= next_state;
      end
    end

    assign o_data[BASE +: LEN_CODED_BLOCK]        = data_q;
    assign o_valid[k]                             = valid_q;
    assign o_sh_error[k]                          = err_q;
    assign o_sh_err_cnt[k*NB_ERR_CNT +: NB_ERR_CNT] = cnt_q;
  end

endmodule

// File: tb/tb_multilane_scrambler.sv
// Randomised scoreboard bench for multilane_scrambler against a bit-serial
// line-history model of the 1+x^39+x^58 scrambler.
module tb_multilane_scrambler;

  localparam int NL = 4;
  localparam int CB = 66;
  localparam int SL = 58;
  localparam int EC = 8;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_enable = 1'b0;
  logic              i_bypass = 1'b0;
  logic              i_mode = 1'b0;
  logic [NL-1:0]     i_valid = '0;
  logic [NL*CB-1:0]  i_data = '0;
  logic              i_seed_load = 1'b0;
  logic [SL-1:0]     i_seed = '0;
  logic              i_clear_cnt = 1'b0;
  logic [NL*CB-1:0]  o_data;
  logic [NL-1:0]     o_valid;
  logic [NL-1:0]     o_sh_error;
  logic [NL*EC-1:0]  o_sh_err_cnt;

  always #5 clk = ~clk;

  multilane_scrambler #(
    .NB_LANES        (NL),
    .LEN_CODED_BLOCK (CB),
    .LEN_SCRAMBLER   (SL),
    .SEED            (58'h0),
    .NB_ERR_CNT      (EC)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_bypass     (i_bypass),
    .i_mode       (i_mode),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_seed_load  (i_seed_load),
    .i_seed       (i_seed),
    .i_clear_cnt  (i_clear_cnt),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_sh_error   (o_sh_error),
    .o_sh_err_cnt (o_sh_err_cnt)
  );

  typedef struct packed {
    logic [NL-1:0]    valid;
    logic [NL-1:0]    err;
    logic [NL*EC-1:0] cnt;
    logic [NL*CB-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference: per lane, the last 58 line bits in transmission order (back = newest).
  bit          hist [NL][$];
  logic [65:0] m_data [NL];
  logic [NL-1:0] m_valid;
  logic [NL-1:0] m_err;
  int          m_cnt [NL];

  task automatic chk(input string name, input int lane, input logic [65:0] got,
                     input logic [65:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s lane=%0d got=%h expected=%h t=%0t", name, lane, got, exp, $time);
    end
  endtask

  function automatic void set_hist(input int k, input logic [SL-1:0] seed);
    hist[k].delete();
    for (int b = SL - 1; b >= 0; b--) hist[k].push_back(seed[b]);
  endfunction

  // s[n] = d[n]^s[n-39]^s[n-58] (scramble) or d[n] = r[n]^r[n-39]^r[n-58].
  function automatic logic [63:0] run_lane(input int k, input logic [63:0] p, input bit descr);
    logic [63:0] res;
    res = '0;
    for (int j = 63; j >= 0; j--) begin
      int n;
      bit o;
      n = hist[k].size();
      o = p[j] ^ hist[k][n-39] ^ hist[k][n-58];
      res[j] = o;
      hist[k].push_back(descr ? p[j] : o);
      void'(hist[k].pop_front());
    end
    return res;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NL; k++) begin
      set_hist(k, '0);
      m_data[k] = '0;
      m_cnt[k]  = 0;
    end
    m_valid = '0;
    m_err   = '0;
  endfunction

  function automatic logic [NL*CB-1:0] model_vec();
    logic [NL*CB-1:0] v;
    for (int k = 0; k < NL; k++) v[k*CB +: CB] = m_data[k];
    return v;
  endfunction

  task automatic step(input bit en, input bit byp, input bit md, input bit sl,
                      input bit clr, input logic [SL-1:0] sd, input logic [NL-1:0] v,
                      input logic [NL*CB-1:0] d);
    exp_t e;
    @(negedge clk);
    i_enable = en; i_bypass = byp; i_mode = md; i_seed_load = sl;
    i_clear_cnt = clr; i_seed = sd; i_valid = v; i_data = d;
    if (en) begin
      for (int k = 0; k < NL; k++) begin
        logic [65:0] blk;
        bit          hb;
        blk = d[k*CB +: CB];
        hb  = md && v[k] && (blk[65:64] == 2'b00 || blk[65:64] == 2'b11);
        m_valid[k] = v[k];
        m_err[k]   = hb;
        if (clr) m_cnt[k] = hb ? 1 : 0;
        else if (hb && m_cnt[k] < 255) m_cnt[k]++;
        if (v[k]) m_data[k] = byp ? blk : {blk[65:64], run_lane(k, blk[63:0], md)};
        if (sl) set_hist(k, sd);
      end
    end
    if (m_valid != '0) begin
      e.valid = m_valid;
      e.err   = m_err;
      e.data  = model_vec();
      for (int k = 0; k < NL; k++) e.cnt[k*EC +: EC] = 8'(m_cnt[k]);
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1; i_valid = '0; i_enable = 1'b1; i_seed_load = 1'b0;
    i_clear_cnt = 1'b0; i_bypass = 1'b0;
    @(negedge clk);
    i_reset = 1'b0;
    model_reset();
    chk("rst_valid", -1, 66'(o_valid), '0);
    chk("rst_sh_error", -1, 66'(o_sh_error), '0);
    chk("rst_cnt", -1, 66'(o_sh_err_cnt), '0);
    for (int k = 0; k < NL; k++) chk("rst_data", k, o_data[k*CB +: CB], '0);
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [NL*CB-1:0] rand_vec();
    logic [NL*CB-1:0] v;
    for (int k = 0; k < NL; k++) v[k*CB +: CB] = {2'($urandom), $urandom, $urandom};
    return v;
  endfunction

  // Monitor: one expectation per cycle in which the DUT presents any valid lane.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!i_reset && o_valid != '0) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output got_valid=%b expected=none t=%0t", o_valid, $time);
        end else begin
          e = sb.pop_front();
          for (int k = 0; k < NL; k++) begin
            chk("valid", k, 66'(o_valid[k]), 66'(e.valid[k]));
            chk("sh_error", k, 66'(o_sh_error[k]), 66'(e.err[k]));
            chk("sh_err_cnt", k, 66'(o_sh_err_cnt[k*EC +: EC]), 66'(e.cnt[k*EC +: EC]));
            if (e.valid[k]) chk("data", k, o_data[k*CB +: CB], e.data[k*CB +: CB]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [NL*CB-1:0] pt[$];
  logic [NL*CB-1:0] ct[$];

  initial begin
    logic [NL*CB-1:0] d;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // All-zero payload through a zero seed stays zero.
    d = '0;
    for (int k = 0; k < NL; k++) d[k*CB +: CB] = {2'b01, 64'h0};
    repeat (2) step(1, 0, 0, 0, 0, '0, '1, d);

    // Capture a scrambled stream for the loopback and self-sync phases.
    for (int i = 0; i < 20; i++) begin
      d = rand_vec();
      step(1, 0, 0, 0, 0, '0, '1, d);
      pt.push_back(d);
      ct.push_back(model_vec());
    end

    for (int i = 0; i < 30; i++)
      step($urandom_range(0, 5) != 0, 0, 0, 0, 0, '0, 4'($urandom), rand_vec());

    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, '0, '1, rand_vec());
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, '0, '1, rand_vec());
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, '0, '1, rand_vec());

    step(1, 0, 0, 1, 0, 58'h1, 4'b0101, rand_vec());
    step(1, 0, 0, 0, 0, '0, '1, rand_vec());
    step(1, 0, 0, 0, 0, '0, '1, rand_vec());

    // Loopback: descrambling the captured stream from the same seed.
    do_reset();
    foreach (ct[i]) step(1, 0, 1, 0, 0, '0, '1, ct[i]);

    // Self-sync from a mismatched seed.
    step(1, 0, 1, 1, 0, {SL{1'b1}}, '0, '0);
    foreach (ct[i]) step(1, 0, 1, 0, 0, '0, '1, ct[i]);

    // Header errors on lane 1 until saturation, with occasional stalls.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      d = rand_vec();
      for (int k = 0; k < NL; k++) d[k*CB+64 +: 2] = (k == 1) ? 2'b00 : good_hdr();
      step((i % 50) != 7, 0, 1, 0, 0, '0, '1, d);
    end
    d = rand_vec();
    for (int k = 0; k < NL; k++) d[k*CB+64 +: 2] = (k == 1) ? 2'b11 : good_hdr();
    step(1, 0, 1, 0, 1, '0, '1, d);
    step(1, 0, 1, 0, 0, '0, '1, rand_vec());

    @(negedge clk);
    i_valid = '0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", -1, 66'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
